// File: rtl/load_align_unit_if.sv
// Signal bundle between the load align unit and its environment.
// The environment is the pipeline plus data memory. It drives the master side, and the unit is the slave.
interface load_align_unit_if;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_addr;
   logic [1:0]  ld_size;
   logic        ld_unsigned;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   logic        wb_valid;
   logic [31:0] wb_data;
   logic        misalign;
   logic        err;
   logic        busy;

   modport master (
      output ld_valid, ld_addr, ld_size, ld_unsigned,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  ld_ready, mem_req, mem_addr,
      input  wb_valid, wb_data, misalign, err, busy
   );

   modport slave (
      input  ld_valid, ld_addr, ld_size, ld_unsigned,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output ld_ready, mem_req, mem_addr,
      output wb_valid, wb_data, misalign, err, busy
   );
endinterface

// File: rtl/load_align_unit.sv
// MEM-stage load front end. It issues one word-aligned read at a time and selects the
// addressed byte or halfword lane. It then sign- or zero-extends that lane for writeback.
module load_align_unit #(
   parameter bit          BIG_ENDIAN  = 1'b0,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input logic              Clk,
   input logic              Rst,
   load_align_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RSP,
      DONE
   } state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] data_q, data_d;
   logic        mis_q, mis_d;
   logic        err_q, err_d;

   logic        req_misaligned;
   logic [31:0] rdata_ext;

   function automatic logic [31:0] align_extend(input logic [31:0] rdata,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        uns);
      logic [1:0]  byte_sel;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      // Big-endian lane 3-a is simply the bitwise inverse of a 2-bit lane index.
      byte_sel = BIG_ENDIAN ? ~lane : lane;
      case (byte_sel)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = (lane[1] ^ BIG_ENDIAN) ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
         SZ_HALF: r = {{16{h[15] & ~uns}}, h};
         default: r = rdata;
      endcase
      return r;
   endfunction

   assign req_misaligned = (bus.ld_size == 2'b11)
                         | ((bus.ld_size == SZ_HALF) & bus.ld_addr[0])
                         | ((bus.ld_size == SZ_WORD) & (bus.ld_addr[1:0] != 2'b00));

   assign rdata_ext = align_extend(bus.mem_rdata, lane_q, size_q, uns_q);

   // NOTE: every state register updates with <= so all flops see the pre-edge values of each other.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         lane_q  <= 2'b00;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         mis_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         mis_q   <= mis_d;
         err_q   <= err_d;
      end
   end

   // NOTE: every next-state signal is given a hold default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      mis_d   = mis_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (bus.ld_valid) begin
               lane_d = bus.ld_addr[1:0];
               size_d = bus.ld_size;
               uns_d  = bus.ld_unsigned;
               if (req_misaligned) begin
                  state_d = DONE;
                  mis_d   = 1'b1;
                  data_d  = '0;
               end else begin
                  state_d = REQ;
                  addr_d  = {bus.ld_addr[31:2], 2'b00};
               end
            end
         end
         REQ: begin
            if (bus.mem_gnt) begin
               cnt_d = '0;
               if (bus.mem_rvalid) begin
                  data_d  = rdata_ext;
                  state_d = DONE;
               end else begin
                  state_d = WAIT_RSP;
               end
            end
         end
         WAIT_RSP: begin
            // A response landing on the final wait cycle beats the timeout.
            if (bus.mem_rvalid) begin
               data_d  = rdata_ext;
               state_d = DONE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               err_d   = 1'b1;
               data_d  = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
            data_d  = '0;
            mis_d   = 1'b0;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ld_ready = (state_q == IDLE);
   assign bus.busy     = (state_q != IDLE);
   assign bus.mem_req  = (state_q == REQ);
   assign bus.mem_addr = addr_q;
   assign bus.wb_valid = (state_q == DONE);
   assign bus.wb_data  = data_q;
   assign bus.misalign = mis_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit. It has a little-endian DUT with a scripted memory responder.
// It also has a big-endian DUT whose memory grants and responds every cycle.
module tb_load_align_unit;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] rdata;
      logic [31:0] exp_data;
      logic        exp_mis;
      logic        exp_err;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        mis;
      logic        err;
      int          exp_cyc;
   } exp_t;

   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   load_align_unit_if mif ();
   load_align_unit_if bif ();

   load_align_unit #(.BIG_ENDIAN(1'b0), .MEM_TIMEOUT(8)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (mif.slave)
   );

   load_align_unit #(.BIG_ENDIAN(1'b1), .MEM_TIMEOUT(8)) dut_be (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bif.slave)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb[$];

   // Memory responder knobs.
   int          gnt_delay = 0;
   int          rsp_delay = 1;
   bit          rsp_en    = 1'b1;
   bit          inject_rvalid = 1'b0;
   logic [31:0] mem_word  = '0;
   int          req_cnt   = 0;
   int          wait_cnt  = 0;
   bit          pending   = 1'b0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // The responder grants after gnt_delay request cycles. It returns data rsp_delay cycles after the grant, and 0 means the same cycle.
   always @(negedge Clk) begin
      mif.mem_gnt    = 1'b0;
      mif.mem_rvalid = 1'b0;
      mif.mem_rdata  = mem_word;
      if (Rst) req_cnt = 0;
      if (inject_rvalid) begin
         mif.mem_rvalid = 1'b1;
         inject_rvalid  = 1'b0;
      end else if (pending) begin
         wait_cnt++;
         if (wait_cnt == rsp_delay) begin
            mif.mem_rvalid = 1'b1;
            pending        = 1'b0;
         end
      end else if (mif.mem_req && !Rst) begin
         if (req_cnt == gnt_delay) begin
            mif.mem_gnt = 1'b1;
            req_cnt     = 0;
            if (rsp_en) begin
               if (rsp_delay == 0) mif.mem_rvalid = 1'b1;
               else begin
                  pending  = 1'b1;
                  wait_cnt = 0;
               end
            end
         end else begin
            req_cnt++;
         end
      end
   end

   // Scoreboard: each writeback pulse is matched against the oldest expected result.
   always @(negedge Clk) begin
      exp_t e;
      if (!Rst && mif.wb_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_wb_valid", {31'b0, mif.wb_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("wb_data", mif.wb_data, e.data);
            check("wb_misalign", {31'b0, mif.misalign}, {31'b0, e.mis});
            check("wb_err", {31'b0, mif.err}, {31'b0, e.err});
            if (e.exp_cyc >= 0) check("wb_latency_cycle", cyc, e.exp_cyc);
         end
      end
   end

   task automatic issue(input vec_t v, input bit push);
      exp_t e;
      int   n;
      n = 0;
      mif.ld_valid    = 1'b1;
      mif.ld_addr     = v.addr;
      mif.ld_size     = v.size;
      mif.ld_unsigned = v.uns;
      while (!mif.ld_ready && n < 100) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 100) check("ld_ready_timeout", {31'b0, mif.ld_ready}, 32'd1);
      if (push) begin
         e.data    = v.exp_data;
         e.mis     = v.exp_mis;
         e.err     = v.exp_err;
         e.exp_cyc = (v.lat < 0) ? -1 : cyc + v.lat;
         sb.push_back(e);
      end
      @(negedge Clk);
      mif.ld_valid = 1'b0;
      if (v.exp_mis) begin
         check("no_mem_req_on_misalign", {31'b0, mif.mem_req}, 32'd0);
      end else begin
         check("mem_req_after_accept", {31'b0, mif.mem_req}, 32'd1);
         check("mem_addr", mif.mem_addr, {v.addr[31:2], 2'b00});
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || !mif.ld_ready) && n < 200) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 200) check("drain_timeout", sb.size(), 32'd0);
   endtask

   task automatic be_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                          input logic [31:0] exp);
      int n;
      n = 0;
      bif.ld_valid    = 1'b1;
      bif.ld_addr     = addr;
      bif.ld_size     = size;
      bif.ld_unsigned = uns;
      @(negedge Clk);
      bif.ld_valid = 1'b0;
      while (!bif.wb_valid && n < 10) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 10) check("be_wb_timeout", {31'b0, bif.wb_valid}, 32'd1);
      check("be_wb_data", bif.wb_data, exp);
      check("be_gnt_rvalid_same_cycle_latency", n, 32'd1);
      @(negedge Clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   vec_t vecs[14];
   vec_t v;

   initial begin
      vecs[0]  = '{32'h0000_1003, 2'b00, 1'b0, 32'h8011_2233, 32'hFFFF_FF80, 1'b0, 1'b0, 3};
      vecs[1]  = '{32'h0000_2002, 2'b01, 1'b1, 32'h9ABC_1234, 32'h0000_9ABC, 1'b0, 1'b0, 3};
      vecs[2]  = '{32'h0000_3002, 2'b10, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1};
      vecs[3]  = '{32'h0000_4000, 2'b11, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1};
      vecs[4]  = '{32'h0000_1001, 2'b00, 1'b1, 32'h8011_2233, 32'h0000_0022, 1'b0, 1'b0, 3};
      vecs[5]  = '{32'h0000_1000, 2'b00, 1'b0, 32'h0000_00F0, 32'hFFFF_FFF0, 1'b0, 1'b0, 3};
      vecs[6]  = '{32'h0000_2000, 2'b01, 1'b0, 32'h0000_8001, 32'hFFFF_8001, 1'b0, 1'b0, 3};
      vecs[7]  = '{32'h0000_2002, 2'b01, 1'b0, 32'h7FFF_8001, 32'h0000_7FFF, 1'b0, 1'b0, 3};
      vecs[8]  = '{32'h0000_3000, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 3};
      vecs[9]  = '{32'h0000_2001, 2'b01, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1};
      vecs[10] = '{32'h0000_1002, 2'b00, 1'b1, 32'h00AB_0000, 32'h0000_00AB, 1'b0, 1'b0, 3};
      vecs[11] = '{32'h0000_1002, 2'b00, 1'b0, 32'h00AB_0000, 32'hFFFF_FFAB, 1'b0, 1'b0, 3};
      vecs[12] = '{32'h0000_5000, 2'b01, 1'b1, 32'h1234_FEDC, 32'h0000_FEDC, 1'b0, 1'b0, 3};
      vecs[13] = '{32'h0000_6004, 2'b10, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 3};

      Rst             = 1'b1;
      mif.ld_valid    = 1'b0;
      mif.ld_addr     = '0;
      mif.ld_size     = '0;
      mif.ld_unsigned = 1'b0;
      bif.ld_valid    = 1'b0;
      bif.ld_addr     = '0;
      bif.ld_size     = '0;
      bif.ld_unsigned = 1'b0;
      bif.mem_gnt     = 1'b1;
      bif.mem_rvalid  = 1'b1;
      bif.mem_rdata   = 32'h9ABC_1234;

      repeat (3) @(negedge Clk);
      check("rst_ld_ready", {31'b0, mif.ld_ready}, 32'd1);
      check("rst_busy", {31'b0, mif.busy}, 32'd0);
      check("rst_mem_req", {31'b0, mif.mem_req}, 32'd0);
      check("rst_mem_addr", mif.mem_addr, 32'd0);
      check("rst_wb_valid", {31'b0, mif.wb_valid}, 32'd0);
      check("rst_wb_data", mif.wb_data, 32'd0);
      check("rst_misalign", {31'b0, mif.misalign}, 32'd0);
      check("rst_err", {31'b0, mif.err}, 32'd0);
      Rst = 1'b0;

      foreach (vecs[i]) begin
         mem_word = vecs[i].rdata;
         issue(vecs[i], 1'b1);
         drain();
      end

      // Back-to-back loads with ld_valid held, all served from one memory word.
      mem_word = 32'h8011_2233;
      v = '{32'h0000_1003, 2'b00, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0, 3}; issue(v, 1'b1);
      v = '{32'h0000_1002, 2'b01, 1'b0, 32'h0, 32'hFFFF_8011, 1'b0, 1'b0, 3}; issue(v, 1'b1);
      v = '{32'h0000_1001, 2'b01, 1'b0, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 1}; issue(v, 1'b1);
      v = '{32'h0000_1000, 2'b10, 1'b0, 32'h0, 32'h8011_2233, 1'b0, 1'b0, 3}; issue(v, 1'b1);
      drain();

      // A delayed grant is followed by a memory timeout.
      // The request holds for 5 cycles, and the wait lasts 8 cycles.
      gnt_delay = 4;
      rsp_en    = 1'b0;
      v = '{32'h0000_7000, 2'b10, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b1, 14};
      issue(v, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("req_held_during_gnt_wait", {31'b0, mif.mem_req}, 32'd1);
         check("addr_stable_during_gnt_wait", mif.mem_addr, 32'h0000_7000);
         if (i < 4) @(negedge Clk);
      end
      @(negedge Clk);
      check("req_dropped_after_gnt", {31'b0, mif.mem_req}, 32'd0);
      check("busy_while_waiting", {31'b0, mif.busy}, 32'd1);
      drain();
      check("ld_ready_after_timeout", {31'b0, mif.ld_ready}, 32'd1);
      inject_rvalid = 1'b1;
      repeat (4) begin
         @(negedge Clk);
         check("late_rvalid_no_wb", {31'b0, mif.wb_valid}, 32'd0);
      end
      gnt_delay = 0;
      rsp_en    = 1'b1;

      // A reset lands while the load is in WAIT_RSP, and the response arrives one cycle later.
      rsp_delay = 2;
      mem_word  = 32'h1111_2222;
      v = '{32'h0000_8000, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, -1};
      issue(v, 1'b0);
      @(negedge Clk);
      check("in_wait_before_reset", {31'b0, mif.busy}, 32'd1);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      check("rst_mid_mem_req", {31'b0, mif.mem_req}, 32'd0);
      check("rst_mid_mem_addr", mif.mem_addr, 32'd0);
      check("rst_mid_wb_valid", {31'b0, mif.wb_valid}, 32'd0);
      check("rst_mid_wb_data", mif.wb_data, 32'd0);
      check("rst_mid_flags", {30'b0, mif.misalign, mif.err}, 32'd0);
      check("rst_mid_ld_ready", {31'b0, mif.ld_ready}, 32'd1);
      repeat (4) begin
         @(negedge Clk);
         check("post_reset_rvalid_ignored", {31'b0, mif.wb_valid}, 32'd0);
      end
      rsp_delay = 1;

      mem_word = 32'h0000_00FF;
      v = '{32'h0000_9000, 2'b00, 1'b1, 32'h0, 32'h0000_00FF, 1'b0, 1'b0, 3};
      issue(v, 1'b1);
      drain();

      // Big-endian lane selection; grant and rvalid arrive together in REQ.
      be_load(32'h0000_2002, 2'b01, 1'b1, 32'h0000_1234);
      be_load(32'h0000_2000, 2'b01, 1'b0, 32'hFFFF_9ABC);
      be_load(32'h0000_1003, 2'b00, 1'b1, 32'h0000_0034);
      be_load(32'h0000_1000, 2'b00, 1'b0, 32'hFFFF_FF9A);
      be_load(32'h0000_1001, 2'b00, 1'b0, 32'hFFFF_FFBC);
      be_load(32'h0000_1004, 2'b10, 1'b0, 32'h9ABC_1234);

      check("scoreboard_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
